// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter that shares one UART transmitter among
// NREQ byte-stream requesters. A grant is held for a whole packet, each byte
// is paced against tx_busy, and an owner that stalls is evicted after TIMEOUT
// cycles.
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    grant,
    output logic [DW-1:0]      tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic               abort
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_WAIT_HI = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t            r_state;
    logic [IW-1:0]     r_gidx;
    logic [IW-1:0]     r_last_gidx;
    logic [CW-1:0]     r_stall;
    logic              r_pkt_end;
    logic [NREQ-1:0]   r_grant;
    logic [DW-1:0]     r_tx_data;
    logic              r_tx_start;
    logic              r_abort;

    logic              w_pick_any;
    logic [IW-1:0]     w_pick_idx;
    logic [NREQ-1:0]   w_pick_onehot;
    logic              w_owner_valid;
    logic [DW-1:0]     w_owner_data;
    logic              w_owner_last;
    logic              w_hs;

    // Round-robin pick: first valid requester searching upward from last_grant+1.
    // The loop runs from the farthest candidate back to the nearest so the
    // nearest one overwrites the others.
    always_comb begin
        w_pick_any = 1'b0;
        w_pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_last_gidx) + 1 + k) % NREQ]) begin
                w_pick_any = 1'b1;
                w_pick_idx = IW'((int'(r_last_gidx) + 1 + k) % NREQ);
            end
        end
        w_pick_onehot = '0;
        w_pick_onehot[w_pick_idx] = 1'b1;
    end

    // Owner-side view of the request bus and the byte handshake.
    always_comb begin
        w_owner_valid = req_valid[r_gidx];
        w_owner_data  = req_data[r_gidx*DW +: DW];
        w_owner_last  = req_last[r_gidx];
        w_hs          = (r_state == S_GRANT) && w_owner_valid && !tx_busy;
    end

    assign req_ready = w_hs ? r_grant : '0;
    assign grant     = r_grant;
    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;
    assign abort     = r_abort;

    // Scheduler FSM with all outputs registered; tx_start and abort are single-cycle pulses.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_gidx      <= '0;
            r_last_gidx <= IW'(NREQ - 1);
            r_stall     <= '0;
            r_pkt_end   <= 1'b0;
            r_grant     <= '0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_abort    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_any) begin
                        r_gidx  <= w_pick_idx;
                        r_grant <= w_pick_onehot;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_hs) begin
                        r_tx_data  <= w_owner_data;
                        r_pkt_end  <= w_owner_last;
                        r_tx_start <= 1'b1;
                        r_stall    <= '0;
                        r_state    <= S_WAIT_HI;
                    end else if (!w_owner_valid) begin
                        // Owner went quiet: count towards eviction. The counter
                        // is held while the owner is valid but blocked by tx_busy.
                        if (r_stall >= STALL_LIMIT) begin
                            r_abort     <= 1'b1;
                            r_grant     <= '0;
                            r_last_gidx <= r_gidx;
                            r_stall     <= '0;
                            r_state     <= S_IDLE;
                        end else if (r_stall != '1) begin
                            r_stall <= r_stall + 1'b1;
                        end
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!tx_busy) begin
                        if (r_pkt_end) begin
                            r_grant     <= '0;
                            r_last_gidx <= r_gidx;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_GRANT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler sharing the single on-board UART transmitter (the one driving `UART_TX`) among up to four byte-stream requesters: core MMIO console, button-event reporter, debug dump and spare. It grants one requester at a time, holds the grant for a whole packet (through the byte flagged `last`), and paces bytes against the transmitter's busy flag. A stalled holder is evicted after a timeout. Sits in `top` between the requesters and the UART TX core.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 8: byte width.
- `TIMEOUT`, 1024: GRANT-state cycles with holder `req_valid` low before forced release; ≥2.

- `clk`  in  1  system clock.
- `nrst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  NREQ  requester i has a byte on its `req_data` slice.
- `req_data`  in  NREQ*DW  byte of requester i at bits [i*DW +: DW].
- `req_last`  in  NREQ  byte is the final byte of the packet.
- `req_ready`  out  NREQ  one-hot, combinational; byte accepted this cycle.
- `grant`  out  NREQ  one-hot registered owner; 0 when idle.
- `tx_data`  out  DW  byte to the UART core, registered.
- `tx_start`  out  1  one-cycle registered start pulse to the UART core.
- `tx_busy`  in  1  UART core is shifting a frame.
- `abort`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, GRANT, WAIT_HI, DRAIN.
- IDLE: if any `req_valid`, select the first set bit searching upward from `last_grant+1` (mod NREQ); register `grant`; go to GRANT. If none, stay.
- GRANT: handshake when `req_valid[g] && !tx_busy`: `req_ready[g]=1` this cycle, latch `req_data` slice into `tx_data`, latch `req_last[g]` into `pkt_end`, set `tx_start` next cycle, clear stall counter, go to WAIT_HI. If `req_valid[g]=0`, increment stall counter. When it reaches `TIMEOUT-1` with `req_valid[g]` still low: pulse `abort`, clear `grant`, set `last_grant=g`, go to IDLE.
- WAIT_HI: wait for `tx_busy=1`, then go to DRAIN.
- DRAIN: wait for `tx_busy=0`. If `pkt_end`: clear `grant`, set `last_grant=g`, go to IDLE. Else return to GRANT with the same owner.
- `req_ready` is zero outside GRANT and for all non-owners. Non-owner `req_valid` is ignored until the owner releases.
- Requesters must hold `req_valid`/`req_data`/`req_last` stable until `req_ready` is seen. A drop without handshake is legal and feeds the stall counter.
- Stall counter width: clog2(TIMEOUT)+1 bits; saturating, never wraps.

## Timing
- Reset values: `grant=0`, `req_ready=0`, `tx_data=0`, `tx_start=0`, `abort=0`, `pkt_end=0`, state IDLE, stall counter 0, `last_grant=NREQ-1` (requester 0 wins the first arbitration). Assertion mid-packet discards the packet immediately. There is no cleanup pulse.
- `req_valid` rising at cycle 0 in IDLE: `grant` at cycle 1, `req_ready` at cycle 1 if `tx_busy=0`, `tx_start` and `tx_data` at cycle 2.
- Inter-byte turnaround after `tx_busy` falls: GRANT next cycle, so `tx_start` for the following byte comes 2 cycles after the `tx_busy` falling edge.
- Between packets: release into IDLE, then re-arbitrate, with 1 extra cycle.
- Simultaneous requests: round-robin guarantees each waiting requester is served within NREQ-1 packets.
- `tx_busy` already high on GRANT entry: no handshake until it falls. Stall counter does not advance while `req_valid[g]=1`.
- `abort` and `grant` clear in the same cycle. Arbitration after an abort starts one cycle later, from `g+1`.

## Test plan
- Single requester 1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), UART model busy for 10 cycles after each start -> exactly 3 `tx_start` pulses carrying 0x41,0x42,0x43; `grant`=0010 throughout; grant back to 0 after the third busy fall.
- All four requesters valid with 1-byte packets from reset -> grant order 0,1,2,3. Requester 0 re-requests during 3's packet -> order continues 0 after 3.
- Requester 2 mid-packet while requester 0 is valid -> no `req_ready[0]` until 2's `last` byte drains. Bytes never interleave on `tx_data`.
- `TIMEOUT=16`: owner drops `req_valid` after its first byte -> `abort` pulses exactly 16 cycles into GRANT, `grant` clears, next requester granted 1 cycle later.
- `nrst` asserted while in DRAIN -> all outputs 0 immediately. After release, requester 0 wins a tie with requester 3.
- `tx_busy` held high when grant issued -> `req_ready` withheld and no `abort` while `req_valid` stays high; handshake occurs the cycle `tx_busy` falls.
